// File: rtl/data_mem_pipe.sv
// data_mem_pipe: single-port word memory with byte-enabled writes, 1-cycle
// registered reads and a post-reset clearing sweep.
// Ports:
//   clock, reset          - sole clock, synchronous active-high reset
//   req_valid / req_ready - request handshake (ready only once clearing is done)
//   mem_read / mem_write  - request opcode (exactly one must be set)
//   address               - word address; bits above AW-1 must be zero
//   byte_en, WD           - per-byte write enable and write data
//   RD, rd_valid          - registered read data and its one-cycle valid pulse
//   err                   - one-cycle pulse for an illegal accepted request
//   init_done             - high once every word has been cleared
module data_mem_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           address,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [DATA_W-1:0]     WD,
    output logic [DATA_W-1:0]     RD,
    output logic                  rd_valid,
    output logic                  err,
    output logic                  init_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = DATA_W / 8;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          init_we;
    logic          accept;
    logic          illegal;
    logic          wr_en;
    logic          rd_en;

    // Next-state and request decode
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        init_we = 1'b0;
        accept  = 1'b0;
        illegal = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            INIT: begin
                init_we = 1'b1;
                ptr_d   = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                accept  = req_valid;
                // both or neither opcode set, or any out-of-range address bit
                illegal = (mem_read == mem_write) || (|address[31:AW]);
                wr_en   = accept && !illegal && mem_write;
                rd_en   = accept && !illegal && mem_read;
            end
            default: state_d = INIT;
        endcase
    end

    // State, pointer and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= INIT;
            ptr_q    <= '0;
            RD       <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rd_valid <= rd_en;
            err      <= accept && illegal;
            if (rd_en) begin
                RD <= mem[address[AW-1:0]];
            end
        end
    end

    // Array write port; a request coinciding with reset is dropped
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (init_we) begin
                mem[ptr_q] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (byte_en[i]) begin
                        mem[address[AW-1:0]][8*i +: 8] <= WD[8*i +: 8];
                    end
                end
            end
        end
    end

    assign req_ready = (state_q == RUN);
    assign init_done = (state_q == RUN);

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: directed plus randomized bench for data_mem_pipe
// (DATA_W=32, DEPTH=16) against an in-bench behavioural model.
module tb_data_mem_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   address;
    logic [3:0]    byte_en;
    logic [DW-1:0] WD;
    logic [DW-1:0] RD;
    logic          rd_valid;
    logic          err;
    logic          init_done;

    int asserts = 0;
    int fails   = 0;

    data_mem_pipe #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .address   (address),
        .byte_en   (byte_en),
        .WD        (WD),
        .RD        (RD),
        .rd_valid  (rd_valid),
        .err       (err),
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clearing countdown, word array, output pulses
    bit          m_known = 1'b0;
    bit          m_ready;
    int          m_left;
    logic [31:0] m_mem [DP];
    logic [31:0] m_rd;
    bit          m_rdv;
    bit          m_err;

    always @(posedge clock) begin
        if (reset) begin
            m_known = 1'b1;
            m_ready = 1'b0;
            m_left  = DP;
            m_rd    = '0;
            m_rdv   = 1'b0;
            m_err   = 1'b0;
        end else if (m_known) begin
            m_rdv = 1'b0;
            m_err = 1'b0;
            if (!m_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DP; i++) m_mem[i] = '0;
                end
            end else if (req_valid) begin
                if (mem_read == mem_write || address >= DP) begin
                    m_err = 1'b1;
                end else if (mem_write) begin
                    for (int b = 0; b < 4; b++)
                        if (byte_en[b]) m_mem[address][8*b +: 8] = WD[8*b +: 8];
                end else begin
                    m_rd  = m_mem[address];
                    m_rdv = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge
    always @(negedge clock) begin
        if (m_known) begin
            chk("req_ready", 32'(req_ready), 32'(m_ready));
            chk("init_done", 32'(init_done), 32'(m_ready));
            chk("rd_valid",  32'(rd_valid),  32'(m_rdv));
            chk("err",       32'(err),       32'(m_err));
            chk("RD",        RD,             m_rd);
            chk("rdv_err_excl", 32'(rd_valid & err), 32'd0);
        end
    end

    task automatic req(input bit v, input bit r, input bit w, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d);
        req_valid = v;
        mem_read  = r;
        mem_write = w;
        address   = a;
        byte_en   = be;
        WD        = d;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = '0; byte_en = '0; WD = '0;
        @(posedge clock);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_RD", RD, 32'd0);
        reset = 1'b0;
        wait_init("init_cycles");

        for (int a = 0; a < DP; a++) begin
            req(1, 1, 0, 32'(a), 4'h0, 32'h0);
            chk("cleared_word", RD, 32'h0);
            chk("cleared_rdv", 32'(rd_valid), 32'd1);
        end

        req(1, 0, 1, 32'd3, 4'hF, 32'h1234_5678);
        req(1, 1, 0, 32'd3, 4'h0, 32'h0);
        chk("wr_full_rd", RD, 32'h1234_5678);
        chk("wr_full_rdv", 32'(rd_valid), 32'd1);

        req(1, 0, 1, 32'd3, 4'b0101, 32'hAAAA_AAAA);
        req(1, 1, 0, 32'd3, 4'h0, 32'h0);
        chk("wr_partial_rd", RD, 32'h12AA_56AA);

        req(1, 1, 0, 32'd16, 4'h0, 32'h0);
        chk("oob_err", 32'(err), 32'd1);
        chk("oob_rdv", 32'(rd_valid), 32'd0);
        chk("oob_rd_hold", RD, 32'h12AA_56AA);

        req(1, 1, 1, 32'd2, 4'hF, 32'hFFFF_FFFF);
        chk("both_ops_err", 32'(err), 32'd1);
        req(1, 1, 0, 32'd2, 4'h0, 32'h0);
        chk("both_ops_nowrite", RD, 32'h0);

        req(1, 0, 0, 32'd1, 4'h0, 32'h0);
        chk("no_op_err", 32'(err), 32'd1);

        req(1, 0, 1, 32'd3, 4'h0, 32'hDEAD_BEEF);
        chk("be0_no_err", 32'(err), 32'd0);
        req(1, 1, 0, 32'd3, 4'h0, 32'h0);
        chk("be0_unchanged", RD, 32'h12AA_56AA);

        // reset during the fifth clearing cycle
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_init("reinit_cycles");

        for (int k = 0; k < 10; k++) begin
            chk("b2b_ready", 32'(req_ready), 32'd1);
            req(1, 0, 1, 32'd7, 4'hF, 32'(100 + k));
        end
        req(1, 1, 0, 32'd7, 4'h0, 32'h0);
        chk("b2b_last", RD, 32'd109);

        for (int c = 0; c < 500; c++) begin
            logic [31:0] a;
            int op;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                req(1, 0, 1, 32'($urandom_range(0, 15)), 4'hF, $urandom);
                reset = 1'b0;
            end else begin
                a  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 17));
                op = $urandom_range(0, 9);
                req(($urandom_range(0, 5) != 0), (op < 4 || op == 9), (op >= 4),
                    a, 4'($urandom), $urandom);
            end
        end

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words; legal values are powers of two, minimum 4.
REQ-003 SHALL derive localparam AW = clog2(DEPTH) and NB = DATA_W/8; neither is overridable.
REQ-004 SHALL have one clock and synchronous active-high reset: clock  input  1  sole clock, all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high; sampled on rising edge of clock.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 mem_read  input  1  request is a read.
REQ-009 mem_write  input  1  request is a write.
REQ-010 address  input  32  word address; only bits [AW-1:0] index the array.
REQ-011 byte_en  input  NB  per-byte write enable; bit i covers WD[8i+7:8i].
REQ-012 WD  input  DATA_W  write data.
REQ-013 RD  output  DATA_W  read data, registered.
REQ-014 rd_valid  output  1  one-cycle pulse, RD updated by a read this cycle.
REQ-015 err  output  1  one-cycle pulse, the request accepted last cycle was illegal.
REQ-016 init_done  output  1  high once post-reset clearing has completed.

Function
REQ-017 Request is accepted on a rising edge where req_valid && req_ready.
REQ-018 FSM SHALL have states INIT and RUN; reset enters INIT with clear pointer 0.
REQ-019 INIT: write 0 to word[ptr] each cycle and increment ptr; after writing word DEPTH-1, go to RUN; INIT lasts exactly DEPTH cycles.
REQ-020 req_ready = (state == RUN); init_done = (state == RUN); requests are ignored in INIT.
REQ-021 Accepted write with address < DEPTH: for each i with byte_en[i] = 1, word[address][8i+7:8i] <= WD[8i+7:8i]; other bytes are unchanged.
REQ-022 Accepted read with address < DEPTH: RD <= word[address] and rd_valid = 1 on the next cycle; latency is exactly 1.
REQ-023 RD SHALL hold its value until the next accepted read.
REQ-024 An accepted request with mem_read && mem_write, address >= DEPTH (any bit of address[31:AW] set), or neither op set is illegal: there is no array write, RD and rd_valid are unchanged/0, and err = 1 on the next cycle.
REQ-025 A write with byte_en = 0 is legal; it is a no-op with err = 0.
REQ-026 Read and write to the same address in back-to-back cycles: the read returns the data written in the prior cycle (no stale data).
REQ-027 Back-to-back requests are accepted every cycle in RUN (full throughput).
REQ-028 rd_valid and err SHALL never both be 1 in the same cycle.

Reset
REQ-029 On reset: RD = 0, rd_valid = 0, err = 0, init_done = 0, req_ready = 0, state = INIT, ptr = 0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from word 0; a request accepted in the reset cycle is discarded.
REQ-031 All memory contents SHALL read 0 after INIT completes.

Verification (DATA_W=32, DEPTH=16)
REQ-032 Reset for 1 cycle, then idle -> req_ready = 0 for 16 cycles, then init_done = 1; a read of each address 0..15 returns 0.
REQ-033 Write addr 3, WD 0x1234_5678, byte_en 4'hF; next cycle read addr 3 -> on the following cycle RD = 0x1234_5678 and rd_valid = 1.
REQ-034 Then write addr 3, WD 0xAAAA_AAAA, byte_en 4'b0101; read addr 3 -> RD = 0x12AA_56AA.
REQ-035 Read addr 16 -> err = 1, rd_valid = 0, RD unchanged; read with mem_read = mem_write = 1 at addr 2 -> err = 1, and word 2 is still 0.
REQ-036 Assert reset during cycle 5 of INIT -> INIT restarts and spans 16 cycles after reset deasserts; issue writes to addr 7 at every cycle after init_done, incrementing data by 1 -> each is accepted every cycle, and a final read returns the last value written.
